mii_mdio_master: RTL and testbench

MAC-side IEEE 802.3 Clause 22 management master: accepts single register read/write requests from the MAC register bank, serialises them onto MDC/MDIO toward the PHY, and returns read data plus a turnaround error flag. It sits directly upstream of the PHY management port (sig_MDCLK/sig_MDIO) in the eth_mac bench and RTL. The top-level tristate is `sig_MDIO = sig_MDIO_OE ? sig_MDIO_O : 1'bz`, with `sig_MDIO_I = sig_MDIO`.

---
 rtl/mii_mdio_pkg.sv | 18 +
 rtl/mii_mdio_clkdiv.sv | 41 ++++
 rtl/mii_mdio_master.sv | 149 ++++++++++++++
 tb/tb_mii_mdio_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_mdio_pkg.sv
// Shared definitions for the Clause 22 MDIO management master.
// FSM state encoding, frame field constants and phase lengths.
package mii_mdio_pkg;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_e;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam int HDR_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;
  // OP, PHYAD, REGAD, TA, DATA; the constant ST bits are not stored.
  localparam int SR_W      = 30;

endpackage

// File: rtl/mii_mdio_clkdiv.sv
// MDC generator: CLK_DIV cycles low then CLK_DIV cycles high per bit, with
// single-cycle strobes on the system edges where MDC rises and falls.
module mii_mdio_clkdiv #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap     = en && (cnt == CNT_MAX);
  assign rise_stb = wrap && !mdc;
  assign fall_stb = wrap && mdc;

  // Dropping enable parks the divider at count 0 with MDC low, so every
  // frame starts with a full low phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mii_mdio_master.sv
// IEEE 802.3 Clause 22 MDIO master: serialises one register read or write
// per request onto MDC/MDIO and returns read data with a turnaround error flag.
module mii_mdio_master
  import mii_mdio_pkg::*;
#(
  parameter int CLK_DIV = 10,
  parameter int PRE_LEN = 32
) (
  input  logic        sig_CLK,
  input  logic        sig_RESET,
  input  logic        sig_REQ_VALID,
  output logic        sig_REQ_READY,
  input  logic        sig_REQ_WRITE,
  input  logic [4:0]  sig_REQ_PHYAD,
  input  logic [4:0]  sig_REQ_REGAD,
  input  logic [15:0] sig_REQ_WDATA,
  output logic        sig_RSP_VALID,
  output logic [15:0] sig_RSP_RDATA,
  output logic        sig_RSP_ERR,
  output logic        sig_BUSY,
  output logic        sig_MDCLK,
  output logic        sig_MDIO_O,
  output logic        sig_MDIO_OE,
  input  logic        sig_MDIO_I
);

  state_e          state, state_nxt;
  logic [5:0]      bit_cnt, bit_cnt_nxt, last_bit;
  logic [SR_W-1:0] sr, sr_nxt;
  logic            is_wr, is_wr_nxt;
  logic            sample, sample_nxt;
  logic            mdio_o_nxt, mdio_oe_nxt;
  logic [15:0]     rdata_nxt;
  logic            err_nxt;
  logic            clk_en, rise_stb, fall_stb, from_sr;

  assign clk_en        = state inside {PRE, HDR, TA, DATA};
  assign sig_REQ_READY = (state == IDLE);
  assign sig_BUSY      = !sig_REQ_READY;
  assign sig_RSP_VALID = (state == DONE);
  // Bits that came out of the shift register; the two ST bits are constants.
  assign from_sr       = (state == HDR && bit_cnt >= 6'd2) || state == TA || state == DATA;

  mii_mdio_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clk      (sig_CLK),
    .rst      (sig_RESET),
    .en       (clk_en),
    .mdc      (sig_MDCLK),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Line drive {oe, o} for bit c of state s; reads release TA and DATA.
  function automatic logic [1:0] drive_bit(state_e s, logic [5:0] c, logic msb, logic wr);
    case (s)
      PRE:     drive_bit = 2'b11;
      HDR:     drive_bit = {1'b1, (c < 6'd2) ? MDIO_ST[~c[0]] : msb};
      TA,
      DATA:    drive_bit = wr ? {1'b1, msb} : 2'b01;
      default: drive_bit = 2'b01;
    endcase
  endfunction

  always_comb begin
    case (state)
      PRE:     last_bit = 6'(PRE_LEN - 1);
      HDR:     last_bit = 6'(HDR_BITS - 1);
      TA:      last_bit = 6'(TA_BITS - 1);
      default: last_bit = 6'(DATA_BITS - 1);
    endcase
  end

  // NOTE: combinational logic uses blocking assignments and gives every
  // variable a default first, so no latch can be inferred; only the register
  // block below uses non-blocking assignments.
  always_comb begin
    state_nxt                  = state;
    bit_cnt_nxt                = bit_cnt;
    sr_nxt                     = sr;
    is_wr_nxt                  = is_wr;
    sample_nxt                 = sample;
    rdata_nxt                  = sig_RSP_RDATA;
    err_nxt                    = sig_RSP_ERR;
    {mdio_oe_nxt, mdio_o_nxt}  = {sig_MDIO_OE, sig_MDIO_O};
    unique case (state)
      IDLE: begin
        if (sig_REQ_VALID) begin
          is_wr_nxt   = sig_REQ_WRITE;
          sr_nxt      = {sig_REQ_WRITE ? MDIO_OP_WR : MDIO_OP_RD, sig_REQ_PHYAD, sig_REQ_REGAD,
                         sig_REQ_WRITE ? MDIO_TA_WR : 2'b11,
                         sig_REQ_WRITE ? sig_REQ_WDATA : 16'h0000};
          state_nxt   = (PRE_LEN > 0) ? PRE : HDR;
          bit_cnt_nxt = '0;
          {mdio_oe_nxt, mdio_o_nxt} = drive_bit(state_nxt, 6'd0, 1'b0, sig_REQ_WRITE);
        end
      end
      DONE: state_nxt = IDLE;
      default: begin
        if (rise_stb) sample_nxt = sig_MDIO_I;
        if (fall_stb) begin
          // Samples enter at the bottom as frame bits leave the top; after the
          // final shift [15:0] is the read data and [16] the second TA bit.
          if (from_sr) sr_nxt = {sr[SR_W-2:0], sample};
          if (bit_cnt == last_bit) begin
            bit_cnt_nxt = '0;
            case (state)
              PRE:     state_nxt = HDR;
              HDR:     state_nxt = TA;
              TA:      state_nxt = DATA;
              default: state_nxt = DONE;
            endcase
          end else begin
            bit_cnt_nxt = bit_cnt + 6'd1;
          end
          {mdio_oe_nxt, mdio_o_nxt} = drive_bit(state_nxt, bit_cnt_nxt, sr_nxt[SR_W-1], is_wr);
          if (state_nxt == DONE) begin
            rdata_nxt = is_wr ? 16'h0000 : sr_nxt[15:0];
            err_nxt   = !is_wr && sr_nxt[16];
          end
        end
      end
    endcase
  end

  always_ff @(posedge sig_CLK or posedge sig_RESET) begin
    if (sig_RESET) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      sr            <= '0;
      is_wr         <= 1'b0;
      sample        <= 1'b1;
      sig_MDIO_O    <= 1'b1;
      sig_MDIO_OE   <= 1'b0;
      sig_RSP_RDATA <= '0;
      sig_RSP_ERR   <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      sr            <= sr_nxt;
      is_wr         <= is_wr_nxt;
      sample        <= sample_nxt;
      sig_MDIO_O    <= mdio_o_nxt;
      sig_MDIO_OE   <= mdio_oe_nxt;
      sig_RSP_RDATA <= rdata_nxt;
      sig_RSP_ERR   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mii_mdio_master.sv
// Bench for mii_mdio_master: two instances (CLK_DIV=2/PRE_LEN=32 and
// CLK_DIV=3/PRE_LEN=0) driven through a shared request bus and a PHY model.
module tb_mii_mdio_master;

  localparam int DIV_A = 2, PRE_A = 32;
  localparam int DIV_B = 3, PRE_B = 0;

  typedef struct {
    bit          rd;
    bit          present;
    logic [15:0] pd;
    int          pre;
  } cfg_t;

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
    logic        err;
    logic        oe;
    logic        mdc;
    logic [63:0] bits;
    int          nbits;
    int          oe_bad;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [4:0]  req_phyad = '0, req_regad = '0;
  logic [15:0] req_wdata = '0;
  logic        phy_oe = 1'b0, phy_o = 1'b1;

  logic        valid_a, ready_a, rsp_valid_a, rsp_err_a, busy_a, mdc_a, mdo_a, mdoe_a, mdi_a;
  logic        valid_b, ready_b, rsp_valid_b, rsp_err_b, busy_b, mdc_b, mdo_b, mdoe_b, mdi_b;
  logic [15:0] rdata_a, rdata_b;

  assign valid_a = req_valid && !sel;
  assign valid_b = req_valid && sel;
  // Line resolution with a pull-up: DUT drive, else PHY drive, else 1.
  assign mdi_a = mdoe_a ? mdo_a : ((phy_oe && !sel) ? phy_o : 1'b1);
  assign mdi_b = mdoe_b ? mdo_b : ((phy_oe && sel) ? phy_o : 1'b1);

  logic        ready_v, busy_v, rsp_valid_v, mdc_v, mdoe_v, line_v;
  assign ready_v     = sel ? ready_b : ready_a;
  assign busy_v      = sel ? busy_b : busy_a;
  assign rsp_valid_v = sel ? rsp_valid_b : rsp_valid_a;
  assign mdc_v       = sel ? mdc_b : mdc_a;
  assign mdoe_v      = sel ? mdoe_b : mdoe_a;
  assign line_v      = sel ? mdi_b : mdi_a;

  mii_mdio_master #(.CLK_DIV(DIV_A), .PRE_LEN(PRE_A)) dut_a (
    .sig_CLK(clk), .sig_RESET(rst),
    .sig_REQ_VALID(valid_a), .sig_REQ_READY(ready_a), .sig_REQ_WRITE(req_write),
    .sig_REQ_PHYAD(req_phyad), .sig_REQ_REGAD(req_regad), .sig_REQ_WDATA(req_wdata),
    .sig_RSP_VALID(rsp_valid_a), .sig_RSP_RDATA(rdata_a), .sig_RSP_ERR(rsp_err_a),
    .sig_BUSY(busy_a), .sig_MDCLK(mdc_a), .sig_MDIO_O(mdo_a), .sig_MDIO_OE(mdoe_a),
    .sig_MDIO_I(mdi_a)
  );

  mii_mdio_master #(.CLK_DIV(DIV_B), .PRE_LEN(PRE_B)) dut_b (
    .sig_CLK(clk), .sig_RESET(rst),
    .sig_REQ_VALID(valid_b), .sig_REQ_READY(ready_b), .sig_REQ_WRITE(req_write),
    .sig_REQ_PHYAD(req_phyad), .sig_REQ_REGAD(req_regad), .sig_REQ_WDATA(req_wdata),
    .sig_RSP_VALID(rsp_valid_b), .sig_RSP_RDATA(rdata_b), .sig_RSP_ERR(rsp_err_b),
    .sig_BUSY(busy_b), .sig_MDCLK(mdc_b), .sig_MDIO_O(mdo_b), .sig_MDIO_OE(mdoe_b),
    .sig_MDIO_I(mdi_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state: owned by the negedge process below.
  cfg_t        cfg_q[$];
  res_t        res_q[$];
  int          acc_q[$];
  int          rise_idx = 0, nbits = 0, oe_bad = 0;
  logic [63:0] seen = '0;
  logic        mdc_prev = 1'b0;

  always @(negedge clk) begin
    cfg_t c;
    res_t r;
    if (rst) begin
      rise_idx = 0; nbits = 0; oe_bad = 0; seen = '0; mdc_prev = 1'b0;
      phy_oe = 1'b0; phy_o = 1'b1;
      cfg_q.delete(); acc_q.delete();
    end else begin
      if (req_valid && ready_v) acc_q.push_back(cyc + 1);
      if (cfg_q.size() != 0) begin
        c = cfg_q[0];
        if (mdc_v && !mdc_prev) begin
          seen = {seen[62:0], line_v};
          nbits++;
          if (c.rd && rise_idx >= c.pre + 14 && mdoe_v) oe_bad++;
          rise_idx++;
        end
        if (!mdc_v) begin
          // PHY: releases the first TA bit, drives 0 then data MSB first.
          phy_oe = c.rd && c.present && rise_idx >= c.pre + 15 && rise_idx < c.pre + 32;
          phy_o  = (rise_idx >= c.pre + 16 && rise_idx < c.pre + 32) ?
                   c.pd[15 - (rise_idx - c.pre - 16)] : 1'b0;
        end
        if (rsp_valid_v) begin
          r.cyc = cyc; r.rdata = sel ? rdata_b : rdata_a; r.err = sel ? rsp_err_b : rsp_err_a;
          r.oe = mdoe_v; r.mdc = mdc_v; r.bits = seen; r.nbits = nbits; r.oe_bad = oe_bad;
          res_q.push_back(r);
          void'(cfg_q.pop_front());
          rise_idx = 0; nbits = 0; oe_bad = 0; seen = '0; phy_oe = 1'b0;
        end
      end
      mdc_prev = mdc_v;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd, input bit present, input logic [15:0] pd);
    cfg_t c;
    c.rd = !wr; c.present = present; c.pd = pd; c.pre = sel ? PRE_B : PRE_A;
    cfg_q.push_back(c);
    req_write = wr; req_phyad = phy; req_regad = rg; req_wdata = wd; req_valid = 1'b1;
  endtask

  task automatic wait_accept(input string tag, output int t);
    int k = 0;
    while (acc_q.size() == 0 && k < 50) begin tick(); k++; end
    check({tag, " accepted"}, 64'(acc_q.size() != 0), 64'd1);
    t = (acc_q.size() != 0) ? acc_q.pop_front() : -1;
  endtask

  task automatic verify(input string tag, input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                        input logic [15:0] wd, input bit present, input logic [15:0] pd, input int t_acc);
    res_t        r;
    int          k = 0;
    int          pre = sel ? PRE_B : PRE_A;
    int          div = sel ? DIV_B : DIV_A;
    logic [15:0] exp_data;
    logic [31:0] tail;
    logic [63:0] exp_bits;
    while (res_q.size() == 0 && k < (pre + 32) * 2 * div + 50) begin tick(); k++; end
    check({tag, " response"}, 64'(res_q.size()), 64'd1);
    if (res_q.size() == 0) return;
    r        = res_q.pop_front();
    exp_data = wr ? wd : (present ? pd : 16'hFFFF);
    tail     = {2'b01, wr ? 2'b01 : 2'b10, phy, rg, (wr || present) ? 2'b10 : 2'b11, exp_data};
    exp_bits = (((64'd1 << pre) - 64'd1) << 32) | {32'd0, tail};
    check({tag, " latency"}, 64'(r.cyc - t_acc), 64'((pre + 32) * 2 * div));
    check({tag, " rdata"},   64'(r.rdata), 64'(wr ? 16'h0000 : exp_data));
    check({tag, " err"},     64'(r.err), 64'(!wr && !present));
    check({tag, " st bits"}, 64'(r.bits[31 -: 2]), 64'd1);
    check({tag, " frame"},   r.bits, exp_bits);
    check({tag, " nbits"},   64'(r.nbits), 64'(pre + 32));
    check({tag, " mdc/oe at done"}, 64'({r.mdc, r.oe}), 64'd0);
    if (!wr) check({tag, " oe released"}, 64'(r.oe_bad), 64'd0);
  endtask

  task automatic run_single(input string tag, input bit wr, input logic [4:0] phy,
                            input logic [4:0] rg, input logic [15:0] wd, input bit present,
                            input logic [15:0] pd);
    int t;
    drive_req(wr, phy, rg, wd, present, pd);
    wait_accept(tag, t);
    req_valid = 1'b0;
    verify(tag, wr, phy, rg, wd, present, pd, t);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int          t1, t2, k, bad, pulses;
    logic [4:0]  p1, r1, p2, r2;
    logic [15:0] d1, d2;

    tick(); tick();
    check("reset A", {ready_a, busy_a, mdc_a, mdo_a, mdoe_a, rsp_valid_a, rsp_err_a, rdata_a},
          {7'b1001000, 16'h0000});
    check("reset B", {ready_b, busy_b, mdc_b, mdo_b, mdoe_b, rsp_valid_b, rsp_err_b, rdata_b},
          {7'b1001000, 16'h0000});
    #2 rst = 1'b0;
    tick(); tick();

    run_single("wr A",     1'b1, 5'd5, 5'd0, 16'h1140, 1'b0, 16'h0000);
    run_single("rd A",     1'b0, 5'd1, 5'd2, 16'h0000, 1'b1, 16'h796D);
    run_single("rd no-phy",1'b0, 5'd3, 5'd1, 16'h0000, 1'b0, 16'h0000);

    // Back-to-back: valid held high, fields switched right after the first accept.
    p1 = 5'($urandom); r1 = 5'($urandom); d1 = 16'($urandom);
    p2 = 5'($urandom); r2 = 5'($urandom); d2 = 16'($urandom);
    drive_req(1'b1, p1, r1, d1, 1'b0, 16'h0000);
    wait_accept("b2b 1", t1);
    drive_req(1'b0, p2, r2, 16'h0000, 1'b1, d2);
    bad = 0; k = 0;
    while (res_q.size() == 0 && k < (PRE_A + 32) * 2 * DIV_A + 50) begin
      if (ready_v || !busy_v) bad++;
      tick(); k++;
    end
    check("b2b ready low in frame", 64'(bad), 64'd0);
    check("b2b ready after done", 64'(ready_v), 64'd1);
    verify("b2b 1", 1'b1, p1, r1, d1, 1'b0, 16'h0000, t1);
    wait_accept("b2b 2", t2);
    req_valid = 1'b0;
    check("b2b second accept edge", 64'(t2 - t1), 64'((PRE_A + 32) * 2 * DIV_A + 2));
    verify("b2b 2", 1'b0, p2, r2, 16'h0000, 1'b1, d2, t2);

    for (int i = 0; i < 3; i++) begin
      d1 = 16'($urandom);
      run_single("rand A", 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                 1'($urandom), d1);
    end

    // Asynchronous reset during the header of a write, while MDC is high.
    drive_req(1'b1, 5'd9, 5'd4, 16'hA5A5, 1'b0, 16'h0000);
    wait_accept("abort", t1);
    req_valid = 1'b0;
    k = 0;
    while (rise_idx < PRE_A + 4 && k < 400) begin tick(); k++; end
    k = 0;
    while (!mdc_v && k < 10) begin tick(); k++; end
    check("abort mdc/oe before reset", 64'({mdc_v, mdoe_v}), 64'd3);
    #2 rst = 1'b1;
    #1 check("abort immediate", 64'({mdc_v, mdoe_v, ready_v, busy_v}), 64'b0010);
    tick(); tick(); tick();
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rsp_valid_v) pulses++;
    end
    check("abort no response", 64'(pulses + res_q.size()), 64'd0);
    run_single("wr after reset", 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 16'h0000);

    // Preamble-suppressed instance.
    sel = 1'b1;
    tick();
    run_single("wr B", 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 16'h0000);
    d1 = 16'($urandom);
    run_single("rd B", 1'b0, 5'($urandom), 5'($urandom), 16'h0000, 1'b1, d1);
    run_single("rd B no-phy", 1'b0, 5'($urandom), 5'($urandom), 16'h0000, 1'b0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
